taint_sum_monitor: RTL and testbench
====================================

# taint_sum_monitor

Sink-side consumer for the `taint_sum` outputs produced by the PIFT taint cells. DFF cells produce a 1-bit sum; memory cells produce a count of tainted words. The block snapshots a vector of these sums and scans it one source at a time. For every source whose value changed since it was last reported, it emits a timestamped change record over a valid/ready stream. It also publishes the aggregate taint count. It sits in the simulation harness next to the instrumented SoC and feeds the taint log writer.

## Interface
Parameters:
- `NUM_SRC`, 8: number of monitored `taint_sum` sources (≥1).
- `SUM_WIDTH`, 16: width of each source slot. Narrower sums are zero-extended by the instantiator.
- `IDX_WIDTH`, 3: index width; must satisfy 2^IDX_WIDTH ≥ NUM_SRC.
- `CYC_WIDTH`, 32: timestamp counter width.

Ports:
- `CLK`  in  1  clock. The block has one clock; reset is synchronous and active-low.
- `RST_N`  in  1  synchronous reset, active-low.
- `EN`  in  1  when high, a new snapshot may start from IDLE.
- `SRC_SUM`  in  NUM_SRC*SUM_WIDTH  source i occupies bits `[i*SUM_WIDTH +: SUM_WIDTH]`.
- `OUT_VALID`  out  1  change record valid.
- `OUT_READY`  in  1  consumer accepts the record.
- `OUT_CYCLE`  out  CYC_WIDTH  timestamp of the snapshot the record came from.
- `OUT_IDX`  out  IDX_WIDTH  source index.
- `OUT_VALUE`  out  SUM_WIDTH  new sum value.
- `TOTAL`  out  SUM_WIDTH+IDX_WIDTH  sum of all slots in the latest snapshot.
- `SCAN_DONE`  out  1  one-cycle pulse when a scan completes.

## Operation
- **Cycle counter:** free-running, +1 every cycle, wraps modulo 2^CYC_WIDTH.
- **Storage:** `snap[NUM_SRC]` holds the current snapshot; `last[NUM_SRC]` holds the last reported value per source.
- **FSM states:** IDLE, SCAN, EMIT.
- **IDLE:**
  - If `EN`=1: latch `SRC_SUM` into `snap`, latch the current cycle counter into the timestamp register, load `TOTAL` with the unsigned sum of all slots, set idx=0, go to SCAN.
  - Otherwise stay in IDLE.
- **SCAN:**
  - If `snap[idx]` ≠ `last[idx]`, go to EMIT. The idx register is the record index.
  - Otherwise, if idx=NUM_SRC-1, pulse `SCAN_DONE` and go to IDLE; else idx+1.
- **EMIT:**
  - `OUT_VALID`=1, with `OUT_IDX`=idx, `OUT_VALUE`=`snap[idx]`, `OUT_CYCLE`=timestamp.
  - When `OUT_READY`=1: `last[idx]` ← `snap[idx]`. If idx=NUM_SRC-1, pulse `SCAN_DONE` and go to IDLE; else idx+1 and go to SCAN.
- **Record stability:** record fields stay stable while `OUT_VALID`=1 and not accepted. `OUT_VALID` never drops without acceptance, even if `EN` falls.
- **Snapshot isolation:** `SRC_SUM` changes during a scan are ignored until the next snapshot; only `snap` is compared.
- **TOTAL width:** `TOTAL` is computed at SUM_WIDTH+IDX_WIDTH bits and cannot overflow.
- **Indices:** indices ≥ NUM_SRC never occur.
- **Reset (`RST_N`=0 at a `CLK` edge):**
  - State ← IDLE, idx ← 0, cycle counter ← 0.
  - All `last`, `snap`, `TOTAL`, `OUT_*` ← 0; `OUT_VALID` ← 0; `SCAN_DONE` ← 0.
  - Reset mid-EMIT drops the pending record.

## Timing
- **Registered outputs:** all outputs are registered; no combinational path from `SRC_SUM` or `OUT_READY` to any output.
- **Snapshot:** taken at edge t, with `EN`=1 in IDLE. The timestamp equals the counter value before that edge.
- **Scan pace:** the SCAN comparison of index k happens in cycle t+1+k if no earlier emits. An unchanged source costs 1 cycle.
- **First mismatch:** for the first mismatch at k, `OUT_VALID` rises in cycle t+2+k.
- **Handshake cost:** acceptance takes effect at the edge where `OUT_VALID`&`OUT_READY`. The next index is compared in the following cycle, so each changed source costs ≥2 cycles.
- **Minimum scan length:** with no changes, NUM_SRC cycles. `SCAN_DONE` is high in the cycle after the last comparison; IDLE is re-entered in that same cycle. The next snapshot can be taken at that edge, so a new snapshot is taken every NUM_SRC+1 cycles with `EN` held high.
- **`TOTAL` update:** `TOTAL` is valid from cycle t+1 and is updated only at snapshots.

## Test plan
1. **Reset:** hold `RST_N`=0 for 3 cycles with `SRC_SUM` nonzero -> `OUT_VALID`=0, `TOTAL`=0, `SCAN_DONE`=0. After release with `EN`=0, no activity.
2. **All zero:** `SRC_SUM` all zero, `EN`=1, `OUT_READY`=1 -> no records. `SCAN_DONE` pulses every 9 cycles (NUM_SRC=8); `TOTAL`=0.
3. **Single change:** set source 5 to 3 at timestamp 10, `OUT_READY`=1 -> one record {cycle=10, idx=5, value=3}, `TOTAL`=3. The following scan emits nothing.
4. **Backpressure:** sources 0 and 7 change to 1 and 0x40; `OUT_READY`=0 for 5 cycles -> record idx=0 held stable for 5 cycles. After ready, record idx=7 with value 0x40; `TOTAL`=0x41.
5. **Snapshot isolation:** change source 6 from 2 to 9 while the scan is at idx 2 -> the current scan reports no idx 6 record. The next scan reports idx=6, value=9.
6. **Reset mid-EMIT:** assert `RST_N`=0 while `OUT_VALID`=1 -> `OUT_VALID`=0 next cycle. After release, the first scan reports every nonzero source again, since `last` was cleared.

Source files
------------

// File: rtl/taint_sum_monitor.sv
// taint_sum_monitor
// Snapshots a vector of taint_sum values, then walks it one source per cycle.
// Each source whose value differs from the value last reported for it produces
// a timestamped change record on a valid/ready stream. The sum of all slots
// of the latest snapshot is published on TOTAL.
//
// Ports
//   CLK        clock
//   RST_N      synchronous reset, active low
//   EN         allows a new snapshot to start while idle
//   SRC_SUM    packed source sums, source i at [i*SUM_WIDTH +: SUM_WIDTH]
//   OUT_VALID  change record valid
//   OUT_READY  consumer accepts the record
//   OUT_CYCLE  timestamp of the snapshot the record belongs to
//   OUT_IDX    source index of the record
//   OUT_VALUE  new sum value of that source
//   TOTAL      sum of all slots of the latest snapshot
//   SCAN_DONE  one-cycle pulse when a scan completes
module taint_sum_monitor #(
  parameter int NUM_SRC   = 8,
  parameter int SUM_WIDTH = 16,
  parameter int IDX_WIDTH = 3,
  parameter int CYC_WIDTH = 32
) (
  input  logic                           CLK,
  input  logic                           RST_N,
  input  logic                           EN,
  input  logic [NUM_SRC*SUM_WIDTH-1:0]   SRC_SUM,
  output logic                           OUT_VALID,
  input  logic                           OUT_READY,
  output logic [CYC_WIDTH-1:0]           OUT_CYCLE,
  output logic [IDX_WIDTH-1:0]           OUT_IDX,
  output logic [SUM_WIDTH-1:0]           OUT_VALUE,
  output logic [SUM_WIDTH+IDX_WIDTH-1:0] TOTAL,
  output logic                           SCAN_DONE
);

  localparam int TW = SUM_WIDTH + IDX_WIDTH;
  localparam logic [IDX_WIDTH-1:0] LAST_IDX = IDX_WIDTH'(NUM_SRC - 1);

  typedef enum logic [1:0] {S_IDLE, S_SCAN, S_EMIT} state_t;

  state_t                              r_state, w_next;
  logic [NUM_SRC-1:0][SUM_WIDTH-1:0]   w_src;
  logic [NUM_SRC-1:0][SUM_WIDTH-1:0]   r_snap;
  logic [NUM_SRC-1:0][SUM_WIDTH-1:0]   r_last;
  logic [IDX_WIDTH-1:0]                r_idx;
  logic [CYC_WIDTH-1:0]                r_cyc;
  logic [CYC_WIDTH-1:0]                r_ts;
  logic [TW-1:0]                       w_sum;
  logic                                w_diff;
  logic                                w_last;

  assign w_src  = SRC_SUM;
  assign w_diff = (r_snap[r_idx] != r_last[r_idx]);
  assign w_last = (r_idx == LAST_IDX);

  // Sum is taken straight off the input so TOTAL lands together with snap.
  always_comb begin
    w_sum = '0;
    for (int i = 0; i < NUM_SRC; i++)
      w_sum = w_sum + TW'(w_src[i]);
  end

  always_ff @(posedge CLK) begin
    if (!RST_N) r_state <= S_IDLE;
    else        r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE: if (EN) w_next = S_SCAN;
      S_SCAN: begin
        if (w_diff)      w_next = S_EMIT;
        else if (w_last) w_next = S_IDLE;
      end
      S_EMIT: if (OUT_READY) w_next = w_last ? S_IDLE : S_SCAN;
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      r_snap    <= '0;
      r_last    <= '0;
      r_idx     <= '0;
      r_cyc     <= '0;
      r_ts      <= '0;
      TOTAL     <= '0;
      OUT_VALID <= 1'b0;
      OUT_CYCLE <= '0;
      OUT_IDX   <= '0;
      OUT_VALUE <= '0;
      SCAN_DONE <= 1'b0;
    end else begin
      r_cyc     <= r_cyc + 1'b1;
      SCAN_DONE <= 1'b0;
      case (r_state)
        S_IDLE: if (EN) begin
          r_snap <= w_src;
          r_ts   <= r_cyc;
          TOTAL  <= w_sum;
          r_idx  <= '0;
        end
        S_SCAN: begin
          if (w_diff) begin
            // Record fields are loaded once here and held through EMIT.
            OUT_VALID <= 1'b1;
            OUT_IDX   <= r_idx;
            OUT_VALUE <= r_snap[r_idx];
            OUT_CYCLE <= r_ts;
          end else if (w_last) begin
            SCAN_DONE <= 1'b1;
          end else begin
            r_idx <= r_idx + 1'b1;
          end
        end
        S_EMIT: if (OUT_READY) begin
          OUT_VALID     <= 1'b0;
          r_last[r_idx] <= r_snap[r_idx];
          if (w_last) SCAN_DONE <= 1'b1;
          else        r_idx     <= r_idx + 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_taint_sum_monitor.sv
module tb_taint_sum_monitor;

  logic              clk = 1'b0;
  logic              RST_N, EN, OUT_READY;
  logic [7:0][15:0]  src;
  logic              OUT_VALID, SCAN_DONE;
  logic [31:0]       OUT_CYCLE;
  logic [2:0]        OUT_IDX;
  logic [15:0]       OUT_VALUE;
  logic [18:0]       TOTAL;

  int n_vec = 0;
  int n_err = 0;
  logic [31:0] cyc;      // cycles since last reset edge
  logic [31:0] ts_exp;   // counter value in the cycle EN was raised
  int rec_idx[16], rec_val[16];
  logic [31:0] rec_cyc[16];
  int n_rec, done_at, first_vld;

  taint_sum_monitor #(.NUM_SRC(8), .SUM_WIDTH(16), .IDX_WIDTH(3), .CYC_WIDTH(32)) dut (
    .CLK(clk), .RST_N(RST_N), .EN(EN), .SRC_SUM(src),
    .OUT_VALID(OUT_VALID), .OUT_READY(OUT_READY), .OUT_CYCLE(OUT_CYCLE),
    .OUT_IDX(OUT_IDX), .OUT_VALUE(OUT_VALUE), .TOTAL(TOTAL), .SCAN_DONE(SCAN_DONE)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (!RST_N) cyc <= 32'd0;
    else        cyc <= cyc + 32'd1;
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    RST_N = 1'b0;
    repeat (3) @(negedge clk);
    RST_N = 1'b1;
  endtask

  // Starts one snapshot at the current negedge and follows it to SCAN_DONE.
  // The first record is refused for 'hold' cycles; src[chg_i] becomes chg_v
  // in scan cycle chg_at (0 = no change).
  task automatic run_scan(input int hold, input int chg_at, input int chg_i, input logic [15:0] chg_v);
    int held;
    logic [2:0]  h_idx;
    logic [15:0] h_val;
    logic [31:0] h_cyc;
    held = 0; n_rec = 0; done_at = 0; first_vld = 0;
    h_idx = '0; h_val = '0; h_cyc = '0;
    EN = 1'b1; OUT_READY = 1'b1; ts_exp = cyc;
    for (int n = 1; n <= 200; n++) begin
      @(negedge clk);
      EN = 1'b0;
      if (n == chg_at) src[chg_i] = chg_v;
      if (OUT_VALID) begin
        if (first_vld == 0) first_vld = n;
        if (n_rec == 0 && held < hold) begin
          if (held == 0) begin
            h_idx = OUT_IDX; h_val = OUT_VALUE; h_cyc = OUT_CYCLE;
          end else begin
            chk("hold_idx", 64'(OUT_IDX), 64'(h_idx));
            chk("hold_val", 64'(OUT_VALUE), 64'(h_val));
            chk("hold_cyc", 64'(OUT_CYCLE), 64'(h_cyc));
          end
          held++;
          OUT_READY = 1'b0;
        end else begin
          if (n_rec < 16) begin
            rec_idx[n_rec] = int'(OUT_IDX);
            rec_val[n_rec] = int'(OUT_VALUE);
            rec_cyc[n_rec] = OUT_CYCLE;
          end
          n_rec++;
          OUT_READY = 1'b1;
        end
      end else begin
        OUT_READY = 1'b1;
      end
      if (SCAN_DONE) begin
        done_at = n;
        break;
      end
    end
    if (done_at == 0) chk("scan_timeout", 64'd0, 64'd1);
    if (hold > 0) chk("held_cycles", 64'(held), 64'(hold));
  endtask

  task automatic chk_rec(input int i, input int idx, input int val);
    chk("rec_idx", 64'(rec_idx[i]), 64'(idx));
    chk("rec_val", 64'(rec_val[i]), 64'(val));
    chk("rec_cyc", 64'(rec_cyc[i]), 64'(ts_exp));
  endtask

  initial begin
    int dn[4];
    int dcnt, vcnt, k;
    RST_N = 1'b0; EN = 1'b0; OUT_READY = 1'b1;
    src = '0;
    src[1] = 16'h1234; src[4] = 16'h0007;

    // 1. reset with nonzero sources, then idle with EN low
    do_reset();
    chk("rst_valid", 64'(OUT_VALID), 64'd0);
    chk("rst_total", 64'(TOTAL), 64'd0);
    chk("rst_done",  64'(SCAN_DONE), 64'd0);
    vcnt = 0; dcnt = 0;
    repeat (6) begin
      @(negedge clk);
      if (OUT_VALID) vcnt++;
      if (SCAN_DONE) dcnt++;
    end
    chk("idle_valid", 64'(vcnt), 64'd0);
    chk("idle_done",  64'(dcnt), 64'd0);
    chk("idle_total", 64'(TOTAL), 64'd0);

    // 2. all zero, EN held high: SCAN_DONE every 9 cycles, no records
    src = '0; EN = 1'b1; OUT_READY = 1'b1;
    vcnt = 0; dcnt = 0;
    for (int n = 1; n <= 60 && dcnt < 4; n++) begin
      @(negedge clk);
      if (OUT_VALID) vcnt++;
      if (SCAN_DONE) begin
        dn[dcnt] = n; dcnt++;
        if (dcnt == 4) EN = 1'b0;
      end
    end
    EN = 1'b0;
    chk("z_pulses", 64'(dcnt), 64'd4);
    chk("z_first",  64'(dn[0]), 64'd9);
    chk("z_gap1",   64'(dn[1] - dn[0]), 64'd9);
    chk("z_gap3",   64'(dn[3] - dn[2]), 64'd9);
    chk("z_valid",  64'(vcnt), 64'd0);
    chk("z_total",  64'(TOTAL), 64'd0);

    // 3. single change: source 5 -> 3, snapshot timestamp 10
    do_reset();
    k = 0;
    while (cyc != 32'd10 && k < 50) begin
      @(negedge clk); k++;
    end
    chk("t3_reach10", 64'(cyc), 64'd10);
    src[5] = 16'd3;
    run_scan(0, 0, 0, 16'd0);
    chk("t3_nrec",  64'(n_rec), 64'd1);
    chk("t3_idx",   64'(rec_idx[0]), 64'd5);
    chk("t3_val",   64'(rec_val[0]), 64'd3);
    chk("t3_cyc",   64'(rec_cyc[0]), 64'd10);
    chk("t3_vrise", 64'(first_vld), 64'd7);
    chk("t3_done",  64'(done_at), 64'd10);
    chk("t3_total", 64'(TOTAL), 64'd3);
    run_scan(0, 0, 0, 16'd0);
    chk("t3b_nrec", 64'(n_rec), 64'd0);
    chk("t3b_done", 64'(done_at), 64'd9);
    chk("t3b_total", 64'(TOTAL), 64'd3);

    // 4. backpressure: sources 0 and 7 change, first record held 5 cycles
    do_reset();
    src = '0; src[0] = 16'd1; src[7] = 16'h0040;
    run_scan(5, 0, 0, 16'd0);
    chk("t4_nrec",  64'(n_rec), 64'd2);
    chk_rec(0, 0, 1);
    chk_rec(1, 7, 16'h40);
    chk("t4_vrise", 64'(first_vld), 64'd2);
    chk("t4_done",  64'(done_at), 64'd16);
    chk("t4_total", 64'(TOTAL), 64'h41);

    // 5. snapshot isolation: source 6 2 -> 9 while scan is at idx 2
    src[6] = 16'd2;
    run_scan(0, 0, 0, 16'd0);
    chk("t5a_nrec", 64'(n_rec), 64'd1);
    chk_rec(0, 6, 2);
    run_scan(0, 3, 6, 16'd9);
    chk("t5b_nrec", 64'(n_rec), 64'd0);
    chk("t5b_total", 64'(TOTAL), 64'h43);
    run_scan(0, 0, 0, 16'd0);
    chk("t5c_nrec", 64'(n_rec), 64'd1);
    chk_rec(0, 6, 9);
    chk("t5c_total", 64'(TOTAL), 64'h4a);

    // 6. reset while a record is pending
    src[3] = 16'd5;
    EN = 1'b1; OUT_READY = 1'b0;
    k = 0;
    do begin
      @(negedge clk); EN = 1'b0; k++;
    end while (!OUT_VALID && k < 20);
    chk("t6_pending", 64'(OUT_VALID), 64'd1);
    chk("t6_pidx",    64'(OUT_IDX), 64'd3);
    RST_N = 1'b0;
    @(negedge clk);
    chk("t6_valid", 64'(OUT_VALID), 64'd0);
    chk("t6_total", 64'(TOTAL), 64'd0);
    chk("t6_value", 64'(OUT_VALUE), 64'd0);
    chk("t6_done",  64'(SCAN_DONE), 64'd0);
    RST_N = 1'b1;
    run_scan(0, 0, 0, 16'd0);
    chk("t6_nrec", 64'(n_rec), 64'd4);
    chk_rec(0, 0, 1);
    chk_rec(1, 3, 5);
    chk_rec(2, 6, 9);
    chk_rec(3, 7, 16'h40);
    chk("t6_total2", 64'(TOTAL), 64'h4f);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
